fu_ls_queue: RTL and testbench

- Multi-entry load/store address-generation unit; replaces the single-slot LS functional unit.
- Buffers up to DEPTH dispatched memory ops and captures late operands from the CDB by tag.
- Computes effective address (rs1 + imm) strictly in program order and hands ops to the memory stage over a valid/ready handshake.
- Flags misaligned accesses; flushes completely on squash.

---
 rtl/fu_ls_queue.sv | 140 ++++++++++++++
 tb/tb_fu_ls_queue.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fu_ls_queue.sv
// Load/store address-generation queue: buffers dispatched memory ops, wakes operands
// from the CDB by tag, and issues rs1+imm in program order into a single output register.
module fu_ls_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       squash,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_rd_mem,
  input  logic                       in_wr_mem,
  input  logic [2:0]                 in_mem_size,
  input  logic [XLEN-1:0]            in_imm,
  input  logic [XLEN-1:0]            in_rs1_value,
  input  logic [XLEN-1:0]            in_rs2_value,
  input  logic                       in_rs1_valid,
  input  logic                       in_rs2_valid,
  input  logic [TAG_W-1:0]           in_rs1_tag,
  input  logic [TAG_W-1:0]           in_rs2_tag,
  input  logic [TAG_W-1:0]           in_dest_tag,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [XLEN-1:0]            cdb_value,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_addr,
  output logic [XLEN-1:0]            out_store_data,
  output logic                       out_rd_mem,
  output logic                       out_wr_mem,
  output logic [2:0]                 out_mem_size,
  output logic [TAG_W-1:0]           out_dest_tag,
  output logic                       out_misaligned,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Both ports: a transfer happens at an edge where valid && ready; the sender holds
  // its payload stable while valid && !ready, and ready never depends on same-cycle valid.

  logic [DEPTH-1:0] e_valid, e_rd, e_wr, e_rs1_rdy, e_rs2_rdy;
  logic [2:0]       e_size    [DEPTH];
  logic [XLEN-1:0]  e_imm     [DEPTH];
  logic [XLEN-1:0]  e_rs1_val [DEPTH];
  logic [XLEN-1:0]  e_rs2_val [DEPTH];
  logic [TAG_W-1:0] e_rs1_tag [DEPTH];
  logic [TAG_W-1:0] e_rs2_tag [DEPTH];
  logic [TAG_W-1:0] e_dest    [DEPTH];

  logic [PW-1:0]   head, tail;
  logic            enq, deq, head_ready;
  logic            in_rs1_hit, in_rs2_hit;
  logic [XLEN-1:0] head_addr;
  logic            head_misaligned;

  assign in_ready   = (count != CW'(DEPTH));
  assign enq        = in_valid && in_ready;
  // Only a store that is not also a load waits on rs2.
  assign head_ready = e_valid[head] && e_rs1_rdy[head] &&
                      (e_rs2_rdy[head] || !(e_wr[head] && !e_rd[head]));
  assign deq        = head_ready && (!out_valid || out_ready);
  assign in_rs1_hit = cdb_valid && (cdb_tag == in_rs1_tag);
  assign in_rs2_hit = cdb_valid && (cdb_tag == in_rs2_tag);
  assign head_addr  = e_rs1_val[head] + e_imm[head];

  always_comb begin
    head_misaligned = 1'b0;
    case (e_size[head][1:0])
      2'b01:   head_misaligned = head_addr[0];
      2'b10:   head_misaligned = (head_addr[1:0] != 2'b00);
      default: head_misaligned = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || squash) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      e_valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cdb_valid && e_valid[i] && !e_rs1_rdy[i] && (e_rs1_tag[i] == cdb_tag)) begin
          e_rs1_val[i] <= cdb_value;
          e_rs1_rdy[i] <= 1'b1;
        end
        if (cdb_valid && e_valid[i] && !e_rs2_rdy[i] && (e_rs2_tag[i] == cdb_tag)) begin
          e_rs2_val[i] <= cdb_value;
          e_rs2_rdy[i] <= 1'b1;
        end
      end
      // tail never aliases a live entry here: enq implies count < DEPTH.
      if (enq) begin
        e_valid[tail]   <= 1'b1;
        e_rd[tail]      <= in_rd_mem;
        e_wr[tail]      <= in_wr_mem;
        e_size[tail]    <= in_mem_size;
        e_imm[tail]     <= in_imm;
        e_dest[tail]    <= in_dest_tag;
        e_rs1_tag[tail] <= in_rs1_tag;
        e_rs2_tag[tail] <= in_rs2_tag;
        e_rs1_rdy[tail] <= in_rs1_valid || in_rs1_hit;
        e_rs2_rdy[tail] <= in_rs2_valid || in_rs2_hit;
        e_rs1_val[tail] <= in_rs1_valid ? in_rs1_value : cdb_value;
        e_rs2_val[tail] <= in_rs2_valid ? in_rs2_value : cdb_value;
        tail            <= tail + PW'(1);
      end
      if (deq) begin
        e_valid[head] <= 1'b0;
        head          <= head + PW'(1);
      end
      count <= count + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || squash || (!deq && out_valid && out_ready)) begin
      out_valid      <= 1'b0;
      out_addr       <= '0;
      out_store_data <= '0;
      out_rd_mem     <= 1'b0;
      out_wr_mem     <= 1'b0;
      out_mem_size   <= '0;
      out_dest_tag   <= '0;
      out_misaligned <= 1'b0;
    end else if (deq) begin
      out_valid      <= 1'b1;
      out_addr       <= head_addr;
      out_store_data <= e_rs2_val[head];
      out_rd_mem     <= e_rd[head];
      out_wr_mem     <= e_wr[head];
      out_mem_size   <= e_size[head];
      out_dest_tag   <= e_dest[head];
      out_misaligned <= head_misaligned;
    end
  end
endmodule

// File: tb/tb_fu_ls_queue.sv
// Bench for fu_ls_queue: directed scenarios then random traffic, all checked every
// cycle against a program-order queue model plus an issued-address scoreboard.
module tb_fu_ls_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int TAG_W = 5;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clock = 1'b0;
  logic             reset = 1'b1, squash = 1'b0;
  logic             in_valid = 1'b0, in_ready;
  logic             in_rd_mem = 1'b0, in_wr_mem = 1'b0;
  logic [2:0]       in_mem_size = '0;
  logic [XLEN-1:0]  in_imm = '0, in_rs1_value = '0, in_rs2_value = '0;
  logic             in_rs1_valid = 1'b0, in_rs2_valid = 1'b0;
  logic [TAG_W-1:0] in_rs1_tag = '0, in_rs2_tag = '0, in_dest_tag = '0;
  logic             cdb_valid = 1'b0;
  logic [TAG_W-1:0] cdb_tag = '0;
  logic [XLEN-1:0]  cdb_value = '0;
  logic             out_valid, out_ready = 1'b0;
  logic [XLEN-1:0]  out_addr, out_store_data;
  logic             out_rd_mem, out_wr_mem, out_misaligned;
  logic [2:0]       out_mem_size;
  logic [TAG_W-1:0] out_dest_tag;
  logic [CW-1:0]    count;

  fu_ls_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd_mem(in_rd_mem), .in_wr_mem(in_wr_mem),
    .in_mem_size(in_mem_size), .in_imm(in_imm), .in_rs1_value(in_rs1_value),
    .in_rs2_value(in_rs2_value), .in_rs1_valid(in_rs1_valid), .in_rs2_valid(in_rs2_valid),
    .in_rs1_tag(in_rs1_tag), .in_rs2_tag(in_rs2_tag), .in_dest_tag(in_dest_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_store_data(out_store_data), .out_rd_mem(out_rd_mem), .out_wr_mem(out_wr_mem),
    .out_mem_size(out_mem_size), .out_dest_tag(out_dest_tag),
    .out_misaligned(out_misaligned), .count(count)
  );

  // clock
  always #5 clock = ~clock;

  // reference model: ops in program order, plus the output register contents
  typedef struct {
    logic rd; logic wr; logic [2:0] size;
    logic [XLEN-1:0] imm; logic [XLEN-1:0] rs1; logic [XLEN-1:0] rs2;
    logic r1ok; logic r2ok;
    logic [TAG_W-1:0] t1; logic [TAG_W-1:0] t2; logic [TAG_W-1:0] dest;
  } op_t;

  op_t              mq[$];
  logic             m_valid = 1'b0, m_rd = 1'b0, m_wr = 1'b0, m_mis = 1'b0;
  logic [XLEN-1:0]  m_addr = '0, m_data = '0;
  logic [2:0]       m_size = '0;
  logic [TAG_W-1:0] m_dest = '0;
  logic [XLEN-1:0]  exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_store(input op_t o);
    return o.wr && !o.rd;
  endfunction

  function automatic logic misal(input logic [2:0] size, input logic [XLEN-1:0] a);
    if (size[1:0] == 2'd1) return (a % 2) != 0;
    if (size[1:0] == 2'd2) return (a % 4) != 0;
    return 1'b0;
  endfunction

  task automatic clear_out();
    m_valid = 1'b0; m_addr = '0; m_data = '0; m_rd = 1'b0; m_wr = 1'b0;
    m_size = '0; m_dest = '0; m_mis = 1'b0;
  endtask

  // advance the model across one clock edge using the inputs presented to it
  task automatic model_step();
    op_t h, n;
    bit deq, enq;
    if (reset || squash) begin
      mq.delete(); exp_q.delete(); clear_out();
      return;
    end
    deq = (mq.size() > 0) && mq[0].r1ok && (mq[0].r2ok || !is_store(mq[0])) &&
          (!m_valid || out_ready);
    enq = in_valid && (mq.size() < DEPTH);
    if (deq) begin
      h = mq.pop_front();
      m_valid = 1'b1; m_addr = h.rs1 + h.imm; m_data = h.rs2; m_rd = h.rd; m_wr = h.wr;
      m_size = h.size; m_dest = h.dest; m_mis = misal(h.size, m_addr);
      exp_q.push_back(m_addr);
    end else if (m_valid && out_ready) begin
      clear_out();
    end
    if (cdb_valid) begin
      foreach (mq[i]) begin
        if (!mq[i].r1ok && mq[i].t1 == cdb_tag) begin mq[i].rs1 = cdb_value; mq[i].r1ok = 1'b1; end
        if (!mq[i].r2ok && mq[i].t2 == cdb_tag) begin mq[i].rs2 = cdb_value; mq[i].r2ok = 1'b1; end
      end
    end
    if (enq) begin
      n.rd = in_rd_mem; n.wr = in_wr_mem; n.size = in_mem_size; n.imm = in_imm;
      n.t1 = in_rs1_tag; n.t2 = in_rs2_tag; n.dest = in_dest_tag;
      n.r1ok = in_rs1_valid || (cdb_valid && cdb_tag == in_rs1_tag);
      n.r2ok = in_rs2_valid || (cdb_valid && cdb_tag == in_rs2_tag);
      n.rs1 = in_rs1_valid ? in_rs1_value : cdb_value;
      n.rs2 = in_rs2_valid ? in_rs2_value : cdb_value;
      mq.push_back(n);
    end
  endtask

  task automatic check_all();
    chk("count", count, mq.size());
    chk("in_ready", in_ready, mq.size() != DEPTH);
    chk("out_valid", out_valid, m_valid);
    chk("out_addr", out_addr, m_addr);
    chk("out_rd_mem", out_rd_mem, m_rd);
    chk("out_wr_mem", out_wr_mem, m_wr);
    chk("out_mem_size", out_mem_size, m_size);
    chk("out_dest_tag", out_dest_tag, m_dest);
    chk("out_misaligned", out_misaligned, m_mis);
    // store data is only meaningful for stores (and must be zero when empty)
    if (!m_valid || (m_wr && !m_rd)) chk("out_store_data", out_store_data, m_data);
  endtask

  // driver: scoreboard the handshake, take one edge, compare on the falling edge
  task automatic tick();
    if (out_valid && out_ready && !reset && !squash) begin
      if (exp_q.size() == 0) begin
        checks++;
        assert (0) else begin
          failures++;
          $error("FAIL sb_underflow observed=handshake expected=no_handshake addr=0x%0h", out_addr);
        end
      end else begin
        chk("sb_addr", out_addr, exp_q.pop_front());
      end
    end
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_all();
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic [2:0] size,
                        input logic [XLEN-1:0] imm, input logic [XLEN-1:0] rs1, input logic r1v,
                        input logic [TAG_W-1:0] t1, input logic [XLEN-1:0] rs2, input logic r2v,
                        input logic [TAG_W-1:0] t2, input logic [TAG_W-1:0] dest);
    in_valid = 1'b1; in_rd_mem = rd; in_wr_mem = wr; in_mem_size = size; in_imm = imm;
    in_rs1_value = rs1; in_rs1_valid = r1v; in_rs1_tag = t1;
    in_rs2_value = rs2; in_rs2_valid = r2v; in_rs2_tag = t2; in_dest_tag = dest;
  endtask

  task automatic mis_case(input logic [2:0] size, input logic [XLEN-1:0] imm, input logic exp,
                          input string tag);
    set_op(1, 0, size, imm, 32'h1000, 1, 0, 0, 1, 0, 5'd9);
    tick();
    in_valid = 1'b0;
    tick();
    chk(tag, out_misaligned, exp);
  endtask

  initial begin
    // reset
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("reset_count", count, 0);
    chk("reset_in_ready", in_ready, 1);

    // single ready load: visible after the second edge
    out_ready = 1'b1;
    set_op(1, 0, 3'b010, 32'h10, 32'h1000, 1, 0, 0, 1, 0, 5'd1);
    tick();
    in_valid = 1'b0;
    chk("load_not_yet", out_valid, 0);
    tick();
    chk("load_valid", out_valid, 1);
    chk("load_addr", out_addr, 32'h1010);
    chk("load_mis", out_misaligned, 0);
    chk("load_count", count, 0);
    tick();

    // store waiting on rs2 tag 7
    set_op(0, 1, 3'b010, 32'h4, 32'h2000, 1, 0, 0, 0, 5'd7, 5'd2);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("store_wait", out_valid, 0);
    cdb_valid = 1'b1; cdb_tag = 5'd7; cdb_value = 32'hDEADBEEF;
    tick();
    cdb_valid = 1'b0;
    tick();
    chk("store_data", out_store_data, 32'hDEADBEEF);
    chk("store_wr", out_wr_mem, 1);
    tick();

    // unready head blocks a younger ready load
    set_op(1, 0, 3'b010, 32'h8, 0, 0, 5'd3, 0, 1, 0, 5'd3);
    tick();
    set_op(1, 0, 3'b010, 32'hC, 32'h4000, 1, 0, 0, 1, 0, 5'd4);
    tick();
    in_valid = 1'b0;
    tick();
    chk("order_blocked", out_valid, 0);
    cdb_valid = 1'b1; cdb_tag = 5'd3; cdb_value = 32'h3000;
    tick();
    cdb_valid = 1'b0;
    tick();
    chk("order_first", out_addr, 32'h3008);
    tick();
    chk("order_second", out_addr, 32'h400C);
    tick();

    // fill with the output stalled, then drain with wrap-around
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      set_op(1, 0, 3'b010, 32'(i * 4), 32'h5000, 1, 0, 0, 1, 0, 5'(10 + i));
      tick();
    end
    in_valid = 1'b0;
    chk("full_count", count, DEPTH);
    chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) tick();

    // misalignment by size
    mis_case(3'b001, 32'h3, 1'b1, "mis_half");
    mis_case(3'b010, 32'h2, 1'b1, "mis_word");
    mis_case(3'b000, 32'h3, 1'b0, "mis_byte");
    tick();

    // squash with queued ops, a held output, a live CDB match and a dispatch
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_op(1, 0, 3'b010, 32'(i), 0, 0, 5'd6, 0, 1, 0, 5'(20 + i));
      if (i == 0) begin in_rs1_valid = 1'b1; in_rs1_value = 32'h6000; end
      tick();
    end
    chk("pre_squash_count", count, 3);
    squash = 1'b1; cdb_valid = 1'b1; cdb_tag = 5'd6; cdb_value = 32'h7000;
    tick();
    squash = 1'b0; cdb_valid = 1'b0; in_valid = 1'b0;
    chk("squash_valid", out_valid, 0);
    chk("squash_count", count, 0);
    chk("squash_in_ready", in_ready, 1);
    tick();

    // random traffic
    for (int c = 0; c < 600; c++) begin
      squash    = ($urandom_range(0, 59) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 2))
        0: begin in_rd_mem = 1'b1; in_wr_mem = 1'b0; end
        1: begin in_rd_mem = 1'b0; in_wr_mem = 1'b1; end
        default: begin in_rd_mem = 1'b0; in_wr_mem = 1'b0; end
      endcase
      in_mem_size  = 3'($urandom_range(0, 7));
      in_imm       = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15))
                                                 : 32'($urandom_range(0, 2047));
      in_rs1_value = $urandom;
      in_rs2_value = $urandom;
      in_rs1_valid = ($urandom_range(0, 1) == 1);
      in_rs2_valid = ($urandom_range(0, 1) == 1);
      in_rs1_tag   = 5'($urandom_range(1, 6));
      in_rs2_tag   = 5'($urandom_range(1, 6));
      in_dest_tag  = 5'($urandom_range(0, 31));
      cdb_valid    = ($urandom_range(0, 9) < 4);
      cdb_tag      = 5'($urandom_range(1, 6));
      cdb_value    = $urandom;
      out_ready    = ($urandom_range(0, 9) < 7);
      tick();
    end

    in_valid = 1'b0; cdb_valid = 1'b0; squash = 1'b1;
    tick();
    squash = 1'b0;

    // report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
